dmem_arbiter: RTL and testbench

Shares the single data memory between the pipeline MEM stage (core port) and an external debug/loader port (dbg port).
- Fixed core priority, with a starvation guard for the debug port.
- One access in flight at a time; each access is sequenced over MEM_LAT cycles.
- Generates the core stall that holds the pipeline while a core access waits or completes.

---
 rtl/dmem_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the pipeline MEM stage (core
// port) and a debug/loader port (dbg port). The core has fixed priority, and
// the dbg port wins once it has lost STARVE_MAX arbitrations in a row. One
// access is in flight at a time: IDLE -> ISSUE -> (WAIT) -> RESP.
// Optional build macro DMEM_ARB_PERF_EN adds saturating 16-bit performance
// counters (core accesses, dbg accesses, core stall cycles).
module dmem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_funct3,
    output logic                  core_stall,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_rvalid,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    output logic                  dbg_gnt,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  dbg_rvalid,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_funct3,
`ifdef DMEM_ARB_PERF_EN
    output logic [15:0]           perf_core_acc,
    output logic [15:0]           perf_dbg_acc,
    output logic [15:0]           perf_stall_cyc,
`endif
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam int LAT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam logic [SC_W-1:0]  STARVE_LIM = SC_W'(STARVE_MAX);
    // WAIT occupies MEM_LAT-1 cycles; the counter runs down to zero.
    localparam logic [LAT_W-1:0] WAIT_INIT  = LAT_W'((MEM_LAT > 2) ? (MEM_LAT - 2) : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state_q;
    logic                    owner_dbg_q;
    logic [SC_W-1:0]         starve_q;
    logic [SC_W-1:0]         starve_d;
    logic                    we_q;
    logic [DM_ADDRESS-1:0]   addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [2:0]              funct3_q;
    logic [LAT_W-1:0]        lat_q;
    logic                    mem_rd_q;
    logic                    mem_wr_q;
    logic [DATA_W-1:0]       core_rdata_q;
    logic [DATA_W-1:0]       dbg_rdata_q;
    logic                    core_rvalid_q;
    logic                    dbg_rvalid_q;

    logic idle;
    logic dbg_win;
    logic core_win;
    logic sel_we;
    logic resp_next;

    // Arbitration is combinational on this cycle's requests while IDLE.
    assign idle      = (state_q == IDLE);
    assign dbg_win   = idle && dbg_req && ((starve_q == STARVE_LIM) || !core_req);
    assign core_win  = idle && core_req && !dbg_win;
    assign sel_we    = dbg_win ? dbg_we : core_we;
    // Data is valid at the end of the last ISSUE/WAIT cycle; RESP follows.
    assign resp_next = ((state_q == ISSUE) && (MEM_LAT == 1)) ||
                       ((state_q == WAIT) && (lat_q == '0));

    // Starvation counter: counts dbg losses, cleared by a dbg win or no dbg request.
    always_comb begin
        starve_d = starve_q;
        if (idle) begin
            if (!dbg_req || dbg_win) begin
                starve_d = '0;
            end else if (core_win && (starve_q != STARVE_LIM)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    // Access sequencer: latches the winner, strobes memory, captures load data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            owner_dbg_q   <= 1'b0;
            starve_q      <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            funct3_q      <= 3'b000;
            lat_q         <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            core_rdata_q  <= '0;
            dbg_rdata_q   <= '0;
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
        end else begin
            starve_q      <= starve_d;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dbg_win || core_win) begin
                        owner_dbg_q <= dbg_win;
                        we_q        <= sel_we;
                        addr_q      <= dbg_win ? dbg_addr : core_addr;
                        wdata_q     <= dbg_win ? dbg_wdata : core_wdata;
                        funct3_q    <= dbg_win ? 3'b010 : core_funct3;
                        mem_rd_q    <= !sel_we;
                        mem_wr_q    <= sel_we;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!resp_next) begin
                        state_q <= WAIT;
                        lat_q   <= WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (!resp_next) begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            if (resp_next) begin
                state_q       <= RESP;
                core_rvalid_q <= !owner_dbg_q;
                dbg_rvalid_q  <= owner_dbg_q;
                if (!we_q) begin
                    if (owner_dbg_q) begin
                        dbg_rdata_q <= mem_rdata;
                    end else begin
                        core_rdata_q <= mem_rdata;
                    end
                end
            end
        end
    end

    // Stall holds the pipeline until the core's own RESP cycle; forced low in reset.
    assign core_stall  = reset && core_req && !((state_q == RESP) && !owner_dbg_q);
    assign dbg_gnt     = reset && dbg_win;
    assign core_rdata  = core_rdata_q;
    assign core_rvalid = core_rvalid_q;
    assign dbg_rdata   = dbg_rdata_q;
    assign dbg_rvalid  = dbg_rvalid_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_funct3  = funct3_q;

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] perf_core_q;
    logic [15:0] perf_dbg_q;
    logic [15:0] perf_stall_q;

    // Saturating event counters: accesses counted on entry to ISSUE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_core_q  <= '0;
            perf_dbg_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (core_win && (perf_core_q != 16'hFFFF)) begin
                perf_core_q <= perf_core_q + 16'd1;
            end
            if (dbg_win && (perf_dbg_q != 16'hFFFF)) begin
                perf_dbg_q <= perf_dbg_q + 16'd1;
            end
            if (core_stall && (perf_stall_q != 16'hFFFF)) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end
        end
    end

    assign perf_core_acc  = perf_core_q;
    assign perf_dbg_acc   = perf_dbg_q;
    assign perf_stall_cyc = perf_stall_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table, starvation and reset sequences, and a
// randomized run checked against a transaction-level model of the arbiter.
// Two instances: u_dut (MEM_LAT = 1) and u_dut3 (MEM_LAT = 3).
module tb_dmem_arbiter;

    localparam int LAT        = 1;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- MEM_LAT = 1 instance ----------------
    logic        reset;
    logic        core_req, core_we, core_stall, core_rvalid;
    logic [8:0]  core_addr;
    logic [31:0] core_wdata, core_rdata;
    logic [2:0]  core_funct3;
    logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [8:0]  dbg_addr;
    logic [31:0] dbg_wdata, dbg_rdata;
    logic        mem_rd, mem_wr;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [2:0]  mem_funct3;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0] perf_core_acc, perf_dbg_acc, perf_stall_cyc;
`endif

    dmem_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .MEM_LAT(LAT), .STARVE_MAX(STARVE_MAX)) u_dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_funct3(core_funct3), .core_stall(core_stall),
        .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3),
`ifdef DMEM_ARB_PERF_EN
        .perf_core_acc(perf_core_acc), .perf_dbg_acc(perf_dbg_acc), .perf_stall_cyc(perf_stall_cyc),
`endif
        .mem_rdata(mem_rdata)
    );

    // ---------------- MEM_LAT = 3 instance ----------------
    logic        reset3;
    logic        l3_core_req, l3_core_we, l3_core_stall, l3_core_rvalid;
    logic [8:0]  l3_core_addr;
    logic [31:0] l3_core_wdata, l3_core_rdata;
    logic [2:0]  l3_core_funct3;
    logic        l3_dbg_req, l3_dbg_we, l3_dbg_gnt, l3_dbg_rvalid;
    logic [8:0]  l3_dbg_addr;
    logic [31:0] l3_dbg_wdata, l3_dbg_rdata;
    logic        l3_mem_rd, l3_mem_wr;
    logic [8:0]  l3_mem_addr;
    logic [31:0] l3_mem_wdata, l3_mem_rdata;
    logic [2:0]  l3_mem_funct3;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0] l3_perf_core_acc, l3_perf_dbg_acc, l3_perf_stall_cyc;
`endif

    dmem_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .MEM_LAT(3), .STARVE_MAX(STARVE_MAX)) u_dut3 (
        .clk(clk), .reset(reset3),
        .core_req(l3_core_req), .core_we(l3_core_we), .core_addr(l3_core_addr),
        .core_wdata(l3_core_wdata), .core_funct3(l3_core_funct3), .core_stall(l3_core_stall),
        .core_rdata(l3_core_rdata), .core_rvalid(l3_core_rvalid),
        .dbg_req(l3_dbg_req), .dbg_we(l3_dbg_we), .dbg_addr(l3_dbg_addr), .dbg_wdata(l3_dbg_wdata),
        .dbg_gnt(l3_dbg_gnt), .dbg_rdata(l3_dbg_rdata), .dbg_rvalid(l3_dbg_rvalid),
        .mem_rd(l3_mem_rd), .mem_wr(l3_mem_wr), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
        .mem_funct3(l3_mem_funct3),
`ifdef DMEM_ARB_PERF_EN
        .perf_core_acc(l3_perf_core_acc), .perf_dbg_acc(l3_perf_dbg_acc), .perf_stall_cyc(l3_perf_stall_cyc),
`endif
        .mem_rdata(l3_mem_rdata)
    );

    // ---------------- memory models ----------------
    function automatic logic [31:0] init_word(input logic [6:0] idx);
        return (idx == 7'd4) ? 32'hDEADBEEF : {16'hC0DE, 9'h000, idx};
    endfunction

    logic [31:0]  mem1 [0:127];
    logic [127:0] mem1_v = '0;
    always @(posedge clk) begin
        if (mem_wr) begin
            mem1[mem_addr[8:2]]   <= mem_wdata;
            mem1_v[mem_addr[8:2]] <= 1'b1;
        end
    end
    // Single-cycle memory: data valid in the strobe cycle.
    assign mem_rdata = mem1_v[mem_addr[8:2]] ? mem1[mem_addr[8:2]] : init_word(mem_addr[8:2]);

    // Three-cycle memory: data valid only from two cycles after the strobe.
    int l3_age = 0;
    always @(posedge clk) begin
        if (l3_mem_rd)
            l3_age <= 1;
        else if (l3_age != 0 && l3_age < 1000)
            l3_age <= l3_age + 1;
    end
    assign l3_mem_rdata = (!l3_mem_rd && l3_age >= 2) ? init_word(l3_mem_addr[8:2]) : 32'hBAD0BAD0;

    // ---------------- reference memory ----------------
    logic [31:0]  mdl_mem [0:127];
    logic [127:0] mdl_v = '0;

    function automatic logic [31:0] mdl_read(input logic [8:0] a);
        return mdl_v[a[8:2]] ? mdl_mem[a[8:2]] : init_word(a[8:2]);
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        port_dbg;
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [5];

    // One isolated transaction on the MEM_LAT=1 instance with cycle-exact checks.
    task automatic do_txn(input vec_t v);
        if (v.port_dbg) begin
            dbg_req = 1'b1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata;
        end else begin
            core_req = 1'b1; core_we = v.we; core_addr = v.addr; core_wdata = v.wdata; core_funct3 = v.f3;
        end
        @(negedge clk);
        chk("gnt_c0", 32'(dbg_gnt), 32'(v.port_dbg));
        chk("stall_c0", 32'(core_stall), 32'(!v.port_dbg));
        chk("rd_c0", 32'(mem_rd), 32'(0));
        step();
        @(negedge clk);
        chk("rd_c1", 32'(mem_rd), 32'(!v.we));
        chk("wr_c1", 32'(mem_wr), 32'(v.we));
        chk("addr_c1", 32'(mem_addr), 32'(v.addr));
        chk("f3_c1", 32'(mem_funct3), 32'(v.port_dbg ? 3'b010 : v.f3));
        if (v.we) chk("wdata_c1", mem_wdata, v.wdata);
        chk("stall_c1", 32'(core_stall), 32'(!v.port_dbg));
        chk("rvalid_c1", 32'({core_rvalid, dbg_rvalid}), 32'(0));
        step();
        @(negedge clk);
        chk("crvalid_c2", 32'(core_rvalid), 32'(!v.port_dbg));
        chk("drvalid_c2", 32'(dbg_rvalid), 32'(v.port_dbg));
        chk("stall_c2", 32'(core_stall), 32'(0));
        if (!v.we) chk("rdata_c2", v.port_dbg ? dbg_rdata : core_rdata, v.exp_rdata);
        step();
        core_req = 1'b0;
        dbg_req  = 1'b0;
        if (v.we) begin
            mdl_mem[v.addr[8:2]] = v.wdata;
            mdl_v[v.addr[8:2]]   = 1'b1;
        end
    endtask

    // Core load on the MEM_LAT=3 instance: strobe in cycle 1, rvalid in cycle 4.
    task automatic lat3_core_load(input logic [31:0] exp);
        l3_core_req = 1'b1; l3_core_we = 1'b0; l3_core_addr = 9'h010;
        l3_core_wdata = 32'h55AA55AA; l3_core_funct3 = 3'b010;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            chk("l3_rd", 32'(l3_mem_rd), 32'(c == 1));
            chk("l3_wr", 32'(l3_mem_wr), 32'(0));
            chk("l3_crvalid", 32'(l3_core_rvalid), 32'(c == 4));
            chk("l3_stall", 32'(l3_core_stall), 32'(c != 4));
            if (c >= 1 && c <= 3) chk("l3_addr", 32'(l3_mem_addr), 32'(9'h010));
            if (c == 1) begin
                chk("l3_wdata", l3_mem_wdata, 32'h55AA55AA);
                chk("l3_f3", 32'(l3_mem_funct3), 32'(3'b010));
            end
            if (c == 4) chk("l3_rdata", l3_core_rdata, exp);
            step();
        end
        l3_core_req = 1'b0;
    endtask

    // Random-phase state
    int          cyc, m_free, m_done, m_win, m_starve;
    logic        m_owner_dbg, m_we, won, w_dbg, c_done, d_done, got;
    logic [8:0]  m_addr;
    logic [2:0]  m_f3;
    logic [31:0] m_exp;
    int          exp_own [10];

    initial begin
        reset = 1'b0; reset3 = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_funct3 = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        l3_core_req = 1'b0; l3_core_we = 1'b0; l3_core_addr = '0; l3_core_wdata = '0; l3_core_funct3 = '0;
        l3_dbg_req = 1'b0; l3_dbg_we = 1'b0; l3_dbg_addr = '0; l3_dbg_wdata = '0;

        vecs[0] = '{1'b1, 1'b1, 9'h020, 32'h12345678, 3'b010, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 9'h020, 32'h0,        3'b010, 32'h12345678};
        vecs[2] = '{1'b0, 1'b0, 9'h010, 32'h0,        3'b010, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b1, 9'h030, 32'hCAFEF00D, 3'b010, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 9'h030, 32'h0,        3'b100, 32'hCAFEF00D};

        // Reset: stall forced low even with core_req high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(core_stall), 32'(0));
        step();
        core_req = 1'b0;
        reset = 1'b1; reset3 = 1'b1;
        @(negedge clk);
        chk("rst_crdata", core_rdata, 32'h0);
        chk("rst_drdata", dbg_rdata, 32'h0);
        chk("rst_strobes", 32'({mem_rd, mem_wr}), 32'(0));
        chk("rst_pulses", 32'({core_rvalid, dbg_rvalid, dbg_gnt, core_stall}), 32'(0));
        step();

        // Directed table.
        for (int i = 0; i < 5; i++) do_txn(vecs[i]);
`ifdef DMEM_ARB_PERF_EN
        chk("perf_core", 32'(perf_core_acc), 32'(3));
        chk("perf_dbg", 32'(perf_dbg_acc), 32'(2));
        chk("perf_stall", 32'(perf_stall_cyc), 32'(6));
`endif

        // Starvation guard: both requests held continuously.
        exp_own = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        core_req = 1'b1; core_we = 1'b0; core_addr = 9'h010; core_funct3 = 3'b010;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h020;
        for (int g = 0; g < 10; g++) begin
            got = 1'b0;
            for (int w = 0; w < 10 && !got; w++) begin
                @(negedge clk);
                if (core_rvalid || dbg_rvalid) begin
                    got = 1'b1;
                    chk("starve_order", 32'(dbg_rvalid), 32'(exp_own[g]));
                    chk("starve_rdata", dbg_rvalid ? dbg_rdata : core_rdata,
                        exp_own[g] != 0 ? 32'h12345678 : 32'hDEADBEEF);
                end
            end
            chk("starve_grant_seen", 32'(got), 32'(1));
        end
        step();
        core_req = 1'b0;
        dbg_req  = 1'b0;

        // Randomized traffic against a transaction-level model.
        m_free = 0; m_done = -100; m_win = -100; m_starve = 0;
        m_owner_dbg = 1'b0; m_we = 1'b0; m_addr = '0; m_f3 = '0; m_exp = '0;
        c_done = 1'b0; d_done = 1'b0;
        for (cyc = 0; cyc < 400; cyc++) begin
            if (c_done) begin
                core_req = 1'b0; c_done = 1'b0;
            end else if (!core_req && $urandom_range(0, 2) == 0) begin
                core_req = 1'b1; core_we = 1'($urandom_range(0, 1));
                core_addr = 9'($urandom_range(0, 15) * 4); core_wdata = $urandom;
                core_funct3 = 3'($urandom_range(0, 7));
            end
            if (d_done) begin
                dbg_req = 1'b0; d_done = 1'b0;
            end else if (!dbg_req && $urandom_range(0, 2) == 0) begin
                dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
                dbg_addr = 9'($urandom_range(0, 15) * 4); dbg_wdata = $urandom;
            end
            @(negedge clk);
            won = 1'b0; w_dbg = 1'b0;
            if (cyc >= m_free) begin
                if (dbg_req && (m_starve == STARVE_MAX || !core_req)) begin
                    won = 1'b1; w_dbg = 1'b1;
                end else if (core_req) begin
                    won = 1'b1;
                end
                if (!dbg_req || w_dbg) m_starve = 0;
                else if (won && m_starve < STARVE_MAX) m_starve++;
                if (won) begin
                    m_win = cyc; m_done = cyc + 1 + LAT; m_free = m_done + 1;
                    m_owner_dbg = w_dbg;
                    m_we   = w_dbg ? dbg_we : core_we;
                    m_addr = w_dbg ? dbg_addr : core_addr;
                    m_f3   = w_dbg ? 3'b010 : core_funct3;
                    if (m_we) begin
                        mdl_mem[m_addr[8:2]] = w_dbg ? dbg_wdata : core_wdata;
                        mdl_v[m_addr[8:2]]   = 1'b1;
                    end else begin
                        m_exp = mdl_read(m_addr);
                    end
                end
            end
            chk("r_gnt", 32'(dbg_gnt), 32'(won && w_dbg));
            chk("r_stall", 32'(core_stall), 32'(core_req && !(cyc == m_done && !m_owner_dbg)));
            chk("r_crvalid", 32'(core_rvalid), 32'(cyc == m_done && !m_owner_dbg));
            chk("r_drvalid", 32'(dbg_rvalid), 32'(cyc == m_done && m_owner_dbg));
            chk("r_rd", 32'(mem_rd), 32'(cyc == m_win + 1 && !m_we));
            chk("r_wr", 32'(mem_wr), 32'(cyc == m_win + 1 && m_we));
            if (cyc == m_win + 1) begin
                chk("r_addr", 32'(mem_addr), 32'(m_addr));
                chk("r_f3", 32'(mem_funct3), 32'(m_f3));
            end
            if (cyc == m_done) begin
                if (!m_we) chk("r_rdata", m_owner_dbg ? dbg_rdata : core_rdata, m_exp);
                if (m_owner_dbg) d_done = 1'b1;
                else             c_done = 1'b1;
            end
            step();
        end
        core_req = 1'b0;
        dbg_req  = 1'b0;

        // MEM_LAT = 3: strobe is a single pulse, address held through WAIT.
        lat3_core_load(32'hDEADBEEF);

        // Reset asserted while a dbg load sits in WAIT.
        l3_dbg_req = 1'b1; l3_dbg_we = 1'b0; l3_dbg_addr = 9'h014;
        @(negedge clk);
        chk("l3_gnt", 32'(l3_dbg_gnt), 32'(1));
        step();
        l3_core_req = 1'b1;
        @(negedge clk);
        chk("l3_issue_rd", 32'(l3_mem_rd), 32'(1));
        chk("l3_stall_wait", 32'(l3_core_stall), 32'(1));
        step();
        @(negedge clk);
        chk("l3_wait_rd", 32'(l3_mem_rd), 32'(0));
        #1 reset3 = 1'b0;
        #1;
        chk("l3_rst_strobes", 32'({l3_mem_rd, l3_mem_wr}), 32'(0));
        chk("l3_rst_drvalid", 32'(l3_dbg_rvalid), 32'(0));
        chk("l3_rst_stall", 32'(l3_core_stall), 32'(0));
        chk("l3_rst_gnt", 32'(l3_dbg_gnt), 32'(0));
        step();
        l3_dbg_req = 1'b0; l3_core_req = 1'b0; reset3 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("l3_post_rvalid", 32'({l3_core_rvalid, l3_dbg_rvalid}), 32'(0));
            chk("l3_post_rd", 32'(l3_mem_rd), 32'(0));
            chk("l3_post_drdata", l3_dbg_rdata, 32'h0);
            step();
        end
        lat3_core_load(32'hDEADBEEF);
`ifdef DMEM_ARB_PERF_EN
        chk("l3_perf_core", 32'(l3_perf_core_acc), 32'(1));
        chk("l3_perf_dbg", 32'(l3_perf_dbg_acc), 32'(0));
        chk("l3_perf_stall", 32'(l3_perf_stall_cyc), 32'(4));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
